// File: rtl/pcie_tx_cpl_framer.sv
// Completion framer: buffers read-completion headers and payload beats in separate FIFOs and
// serialises them into one registered ready/valid TLP beat stream with length checking.
module pcie_tx_cpl_framer #(
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned HDR_DEPTH_LG2 = 4,
  parameter int unsigned PAY_DEPTH_LG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpl_hdr_wren,
  input  logic [127:0]          cpl_hdr_data,
  input  logic                  cpl_pay_wren,
  input  logic [DATA_WIDTH-1:0] cpl_pay_data,
  input  logic                  cpl_pay_last,
  output logic                  cpl_hdr_afull,
  output logic                  cpl_pay_afull,
  output logic                  tlp_out_valid,
  output logic [DATA_WIDTH-1:0] tlp_out_data,
  output logic                  tlp_out_last,
  input  logic                  tlp_out_ready,
  output logic                  err_len,
  output logic                  err_ovf,
  output logic [15:0]           cpl_sent_cnt,
  output logic                  busy
);

  localparam int unsigned HdrDepth     = 1 << HDR_DEPTH_LG2;
  localparam int unsigned PayDepth     = 1 << PAY_DEPTH_LG2;
  localparam int unsigned HdrAfullInt  = HdrDepth - 2;
  localparam int unsigned PayAfullInt  = PayDepth - 2;
  localparam int unsigned Hcw          = HDR_DEPTH_LG2 + 1;
  localparam int unsigned Pcw          = PAY_DEPTH_LG2 + 1;
  localparam int unsigned BeatDw       = DATA_WIDTH / 32;
  localparam logic [HDR_DEPTH_LG2:0] HdrFull  = HdrDepth[HDR_DEPTH_LG2:0];
  localparam logic [HDR_DEPTH_LG2:0] HdrAfull = HdrAfullInt[HDR_DEPTH_LG2:0];
  localparam logic [PAY_DEPTH_LG2:0] PayFull  = PayDepth[PAY_DEPTH_LG2:0];
  localparam logic [PAY_DEPTH_LG2:0] PayAfull = PayAfullInt[PAY_DEPTH_LG2:0];

  typedef enum logic [1:0] {StIdle, StHdr, StPay, StDiscard} state_e;

  logic [127:0]          hdr_mem [HdrDepth];
  logic [DATA_WIDTH:0]   pay_mem [PayDepth];
  logic [HDR_DEPTH_LG2-1:0] hdr_wr_ptr_q, hdr_rd_ptr_q, hdr_rd_nxt;
  logic [PAY_DEPTH_LG2-1:0] pay_wr_ptr_q, pay_rd_ptr_q, pay_rd_nxt;
  logic [HDR_DEPTH_LG2:0]   hdr_cnt_q;
  logic [PAY_DEPTH_LG2:0]   pay_cnt_q;
  logic hdr_push, hdr_pop, pay_push, pay_pop, hs;
  logic [127:0]          hdr_head, hdr_next;
  logic [DATA_WIDTH:0]   pay_head, pay_next;
  logic [10:0]           len_dw, exp_beats, beat_cnt_q;
  logic [11:0]           len_round;
  state_e                state_q;

  function automatic logic [DATA_WIDTH-1:0] hdr_beat(logic [127:0] h);
    logic [DATA_WIDTH-1:0] b;
    b = '0;
    b[127:0] = h;
    return b;
  endfunction

  assign hs         = tlp_out_valid && tlp_out_ready;
  assign hdr_rd_nxt = hdr_rd_ptr_q + HDR_DEPTH_LG2'(1);
  assign pay_rd_nxt = pay_rd_ptr_q + PAY_DEPTH_LG2'(1);
  assign hdr_head   = hdr_mem[hdr_rd_ptr_q];
  assign hdr_next   = hdr_mem[hdr_rd_nxt];
  assign pay_head   = pay_mem[pay_rd_ptr_q];
  assign pay_next   = pay_mem[pay_rd_nxt];

  // Entries stay in the FIFO while presented; they are only popped on the output handshake.
  assign hdr_pop  = (state_q == StHdr) && hs;
  assign pay_pop  = ((state_q == StPay) && hs) || ((state_q == StDiscard) && (pay_cnt_q != '0));
  assign hdr_push = cpl_hdr_wren && ((hdr_cnt_q != HdrFull) || hdr_pop);
  assign pay_push = cpl_pay_wren && ((pay_cnt_q != PayFull) || pay_pop);

  assign cpl_hdr_afull = (hdr_cnt_q >= HdrAfull);
  assign cpl_pay_afull = (pay_cnt_q >= PayAfull);
  assign busy          = (state_q != StIdle);

  // Length 0 encodes 1024 DW.
  assign len_dw    = (hdr_head[9:0] == 10'd0) ? 11'd1024 : {1'b0, hdr_head[9:0]};
  assign len_round = {1'b0, len_dw} + 12'(BeatDw - 1);
  assign exp_beats = 11'(len_round / 12'(BeatDw));

  always_ff @(posedge clk) begin
    if (hdr_push) hdr_mem[hdr_wr_ptr_q] <= cpl_hdr_data;
    if (pay_push) pay_mem[pay_wr_ptr_q] <= {cpl_pay_last, cpl_pay_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_wr_ptr_q <= '0;
      hdr_rd_ptr_q <= '0;
      hdr_cnt_q    <= '0;
      pay_wr_ptr_q <= '0;
      pay_rd_ptr_q <= '0;
      pay_cnt_q    <= '0;
      err_ovf      <= 1'b0;
    end else begin
      if (hdr_push) hdr_wr_ptr_q <= hdr_wr_ptr_q + HDR_DEPTH_LG2'(1);
      if (hdr_pop)  hdr_rd_ptr_q <= hdr_rd_nxt;
      if (hdr_push && !hdr_pop)      hdr_cnt_q <= hdr_cnt_q + Hcw'(1);
      else if (!hdr_push && hdr_pop) hdr_cnt_q <= hdr_cnt_q - Hcw'(1);
      if (pay_push) pay_wr_ptr_q <= pay_wr_ptr_q + PAY_DEPTH_LG2'(1);
      if (pay_pop)  pay_rd_ptr_q <= pay_rd_nxt;
      if (pay_push && !pay_pop)      pay_cnt_q <= pay_cnt_q + Pcw'(1);
      else if (!pay_push && pay_pop) pay_cnt_q <= pay_cnt_q - Pcw'(1);
      if ((cpl_hdr_wren && !hdr_push) || (cpl_pay_wren && !pay_push)) err_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      tlp_out_valid <= 1'b0;
      tlp_out_data  <= '0;
      tlp_out_last  <= 1'b0;
      beat_cnt_q    <= '0;
      err_len       <= 1'b0;
      cpl_sent_cnt  <= '0;
    end else begin
      if (hs && tlp_out_last) cpl_sent_cnt <= cpl_sent_cnt + 16'd1;
      unique case (state_q)
        StIdle: begin
          if (hdr_cnt_q != '0) begin
            state_q       <= StHdr;
            tlp_out_valid <= 1'b1;
            tlp_out_data  <= hdr_beat(hdr_head);
            tlp_out_last  <= !hdr_head[30];
          end
        end
        StHdr: begin
          if (hs) begin
            if (hdr_head[30]) begin
              state_q       <= StPay;
              beat_cnt_q    <= exp_beats;
              tlp_out_valid <= (pay_cnt_q != '0);
              tlp_out_data  <= pay_head[DATA_WIDTH-1:0];
              tlp_out_last  <= pay_head[DATA_WIDTH] || (exp_beats == 11'd1);
            end else if (hdr_cnt_q > Hcw'(1)) begin
              tlp_out_data  <= hdr_beat(hdr_next);
              tlp_out_last  <= !hdr_next[30];
            end else begin
              state_q       <= StIdle;
              tlp_out_valid <= 1'b0;
              tlp_out_last  <= 1'b0;
            end
          end
        end
        StPay: begin
          if (hs && tlp_out_last) begin
            // Last must come from the payload flag exactly when the header count runs out.
            if (!pay_head[DATA_WIDTH] || (beat_cnt_q != 11'd1)) err_len <= 1'b1;
            if (!pay_head[DATA_WIDTH]) begin
              state_q       <= StDiscard;
              tlp_out_valid <= 1'b0;
              tlp_out_last  <= 1'b0;
            end else if (hdr_cnt_q != '0) begin
              state_q       <= StHdr;
              tlp_out_data  <= hdr_beat(hdr_head);
              tlp_out_last  <= !hdr_head[30];
            end else begin
              state_q       <= StIdle;
              tlp_out_valid <= 1'b0;
              tlp_out_last  <= 1'b0;
            end
          end else if (hs) begin
            beat_cnt_q    <= beat_cnt_q - 11'd1;
            tlp_out_valid <= (pay_cnt_q > Pcw'(1));
            tlp_out_data  <= pay_next[DATA_WIDTH-1:0];
            tlp_out_last  <= pay_next[DATA_WIDTH] || (beat_cnt_q == 11'd2);
          end else if (!tlp_out_valid && (pay_cnt_q != '0)) begin
            tlp_out_valid <= 1'b1;
            tlp_out_data  <= pay_head[DATA_WIDTH-1:0];
            tlp_out_last  <= pay_head[DATA_WIDTH] || (beat_cnt_q == 11'd1);
          end
        end
        StDiscard: begin
          if ((pay_cnt_q != '0) && pay_head[DATA_WIDTH]) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/pcie_tx_cpl_framer.md
# pcie_tx_cpl_framer

Transmit-side completion framer directly downstream of the PCIe RX transaction block. It accepts the read-completion header pushes (128-bit TLP header) and payload pushes (`DATA_WIDTH` beats with a last flag) that the RX block emits, and buffers each in its own FIFO. It serialises them into a single ready/valid TLP beat stream toward the link layer. The block checks payload length against the header Length field and recovers from mismatches.

## Interface
Parameters:
- `DATA_WIDTH`: default 256 (`PCIE_PKG::PIPE_DATA_WIDTH`). Payload/stream beat width. Must be ≥128 and a multiple of 32.
- `HDR_DEPTH_LG2`: default 4. log2 of header FIFO depth.
- `PAY_DEPTH_LG2`: default 5. log2 of payload FIFO depth.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `cpl_hdr_wren`  in  1  header push strobe.
- `cpl_hdr_data`  in  128  completion header; DW0 = bits[31:0], Fmt = [31:29], Length = [9:0].
- `cpl_pay_wren`  in  1  payload push strobe.
- `cpl_pay_data`  in  DATA_WIDTH  payload beat.
- `cpl_pay_last`  in  1  marks final payload beat of a completion; qualified by `cpl_pay_wren`.
- `cpl_hdr_afull`  out  1  header FIFO occupancy ≥ depth−2.
- `cpl_pay_afull`  out  1  payload FIFO occupancy ≥ depth−2.
- `tlp_out_valid`  out  1  beat valid.
- `tlp_out_data`  out  DATA_WIDTH  beat data.
- `tlp_out_last`  out  1  final beat of TLP.
- `tlp_out_ready`  in  1  link-layer accept.
- `err_len`  out  1  sticky; payload last flag disagreed with header Length.
- `err_ovf`  out  1  sticky; push to a full FIFO (the push is dropped).
- `cpl_sent_cnt`  out  16  count of TLPs completed on the output, wraps at 0xFFFF→0.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- FIFOs: payload FIFO stores `{last, data}`. Push when full is dropped, sets `err_ovf`, and leaves FIFO contents intact.
- Header decode: has_data = Fmt[1]. len_dw = Length, where 0 means 1024. exp_beats = ceil(len_dw / (DATA_WIDTH/32)), held in an 11-bit counter.
- FSM states: IDLE, HDR, PAY, DISCARD.
- IDLE → HDR when the header FIFO is non-empty.
- HDR drives the header on `tlp_out_data[127:0]` with upper bits zero.
  - `tlp_out_last` = !has_data.
  - On handshake, the header is popped. If has_data, go to PAY with beat counter = exp_beats. Otherwise go to IDLE, or directly to HDR if another header is waiting.
- PAY: `tlp_out_valid` = payload FIFO non-empty. Empty-FIFO gaps inside a TLP are legal. On each handshake the beat is popped and the counter is decremented.
  - Counter reaches 1 and the popped beat has last = 1: normal end, `tlp_out_last` = 1.
  - Popped beat has last = 1 while counter > 1: early end. `tlp_out_last` = 1 on that beat and `err_len` is set.
  - Counter reaches 1 and the popped beat has last = 0: TLP is closed on this beat with `tlp_out_last` = 1, `err_len` is set, next state is DISCARD.
  - After a normal or early end, next state is HDR if a header is waiting, else IDLE.
- DISCARD: pop payload beats with no output (`tlp_out_valid` = 0) until a beat with last = 1 is popped, then go to IDLE.
- `cpl_sent_cnt` increments on every handshake with `tlp_out_last` = 1.
- Header and payload pushes in the same cycle are independent and both accepted.

## Timing
- Reset values:
  - All outputs are 0: `tlp_out_*`, `err_*`, `cpl_sent_cnt`, `busy`, `*_afull`.
  - FIFOs are empty and the FSM is in IDLE.
- Reset asserted mid-TLP aborts the TLP; `tlp_out_valid` is 0 from the first cycle after `rst` is sampled high.
- Latency: a header pushed in cycle N gives `tlp_out_valid` in cycle N+2 earliest (registered FIFO read plus one FSM cycle).
- Output is registered. `tlp_out_data`, `tlp_out_last` and `tlp_out_valid` must hold stable while valid && !ready.
- Throughput: one beat per cycle with `tlp_out_ready` = 1 and FIFOs non-empty. No idle cycle between a last beat and the next header.
- A pop and a push on the same FIFO in the same cycle leave occupancy unchanged, including when the FIFO is full. Pointers wrap modulo depth.
- `afull` is combinational from registered occupancy. Upstream must stop pushing within 1 cycle of `afull` going high.

## Test plan
- CplD, Length = 16 DW, `DATA_WIDTH` = 256, 2 payload beats with last on the 2nd, ready held 1 → 3-beat TLP (header, P0, P1) on consecutive cycles, last on P1, `cpl_sent_cnt` = 1, `err_len` = 0.
- Cpl without data (Fmt = 000) → single beat with `tlp_out_last` = 1. Back-to-back second header → emitted the next cycle with no gap.
- Length = 0 (1024 DW) → 128 payload beats plus header; ready toggled 1/0 every cycle → data stable during stalls, 129 handshakes.
- Length = 24 DW (3 beats) with payload last on beat 2 → TLP ends at beat 2 and `err_len` = 1. Length = 8 DW with last on beat 3 → TLP ends after 1 payload beat, remaining 2 beats discarded, next TLP correct.
- 17 header pushes into a depth-16 FIFO with ready = 0 → `cpl_hdr_afull` asserts at occupancy 14, `err_ovf` = 1, 16 TLPs delivered after ready rises.
- Assert `rst` during payload beat 3 of 8 → `tlp_out_valid` = 0 the next cycle, counters 0, a new CplD after reset framed correctly.
